// File: rtl/arb_serial_adder_pkg.sv
// Shared definitions for the two-requester nibble-serial adder.
package arb_serial_adder_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/arb_serial_adder_nibble_add_ci.sv
// 4-bit ripple-carry adder slice with carry-in.
module nibble_add_ci
  import arb_serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SLICE_W];
  end
endmodule

// File: rtl/arb_serial_adder.sv
// Round-robin arbitrated adder: two requesters share one 4-bit slice that
// walks the operands LSB nibble first, then strobes the registered result.
module arb_serial_adder
  import arb_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             busy
);
  localparam int NIB = WIDTH / SLICE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, id_r, rr_last;
  logic             gnt0, gnt1, hs;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic             sl_co;

  // Ties go to the requester that did not win last; grants are masked in reset.
  assign gnt0 = rst_n && (state == ST_IDLE) && req0_valid && (!req1_valid || rr_last);
  assign gnt1 = rst_n && (state == ST_IDLE) && req1_valid && (!req0_valid || !rr_last);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign hs = gnt0 | gnt1;

  assign sl_a = a_r[cnt*SLICE_W +: SLICE_W];
  assign sl_b = b_r[cnt*SLICE_W +: SLICE_W];

  nibble_add_ci u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_s),
    .cout (sl_co)
  );

  always_comb begin
    sum_nxt = sum_r;
    sum_nxt[cnt*SLICE_W +: SLICE_W] = sl_s;
  end

  always_comb begin
    state_nxt = state;
    res_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: if (hs) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      id_r      <= 1'b0;
      rr_last   <= 1'b1;
      res_id    <= 1'b0;
      res_sum   <= '0;
      res_carry <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (hs) begin
          a_r     <= gnt1 ? req1_a : req0_a;
          b_r     <= gnt1 ? req1_b : req0_b;
          id_r    <= gnt1;
          rr_last <= gnt1;
          carry   <= 1'b0;
          cnt     <= '0;
        end
        ST_RUN: begin
          sum_r <= sum_nxt;
          carry <= sl_co;
          // Result registers only move on the last nibble so they hold between strobes.
          if (cnt == LAST) begin
            res_sum   <= sum_nxt;
            res_carry <= sl_co;
            res_id    <= id_r;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arb_serial_adder.sv
// Self-checking bench for arb_serial_adder: directed cases plus a randomized
// timeline model of arbitration, latency and sums.
module tb_arb_serial_adder;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic r0, r1, res_valid, res_id, res_carry, busy;
  logic [W-1:0] res_sum;
  int checks = 0, errors = 0;

  arb_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1),
    .req0_ready(r0), .req1_ready(r1),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .res_carry(res_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic apply_reset();
    v0 = 1'b0; v1 = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Presents one request, waits (bounded) for grant and result.
  task automatic do_txn(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] s, output logic c, output logic rid,
                        output int wt, output int lat, output logic to);
    to = 1'b0; wt = 0; lat = 0; s = '0; c = 1'b0; rid = 1'b0;
    if (id) begin a1 = a; b1 = b; v1 = 1'b1; end
    else    begin a0 = a; b0 = b; v0 = 1'b1; end
    #1;
    while (!(id ? r1 : r0) && wt < 30) begin @(posedge clk); #1; wt++; end
    if (!(id ? r1 : r0)) begin
      to = 1'b1;
      if (id) v1 = 1'b0; else v0 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble the ports right after the handshake; the sum must not notice.
    if (id) begin v1 = 1'b0; a1 = ~a; b1 = a ^ b; end
    else    begin v0 = 1'b0; a0 = ~a; b0 = a ^ b; end
    lat = 1;
    while (!res_valid && lat <= 20) begin @(posedge clk); #1; lat++; end
    if (!res_valid) to = 1'b1;
    s = res_sum; c = res_carry; rid = res_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({res_valid, busy, res_id, res_carry} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got v=%b busy=%b id=%b c=%b want 0", res_valid, busy, res_id, res_carry); end
    checks++; if (res_sum !== '0) begin errors++;
      $display("FAIL reset_sum got %h want 0", res_sum); end
    checks++; if ({r0, r1} !== 2'b00) begin errors++;
      $display("FAIL reset_ready got %b%b want 00", r0, r1); end
    v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] s; logic c, rid, to; int wt, lat;
    do_txn(1'b0, 16'h1234, 16'h4321, s, c, rid, wt, lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL dir0_timeout"); end
    checks++; if ({c, rid, s} !== {1'b0, 1'b0, 16'h5555}) begin errors++;
      $display("FAIL dir0_result got c=%b id=%b sum=%h want c=0 id=0 sum=5555", c, rid, s); end
    checks++; if (lat !== NIB + 1) begin errors++;
      $display("FAIL dir0_latency got %0d want %0d", lat, NIB + 1); end
    checks++; if ({res_valid, res_sum} !== {1'b0, 16'h5555}) begin errors++;
      $display("FAIL dir0_hold got v=%b sum=%h want v=0 sum=5555", res_valid, res_sum); end
    do_txn(1'b1, 16'hFFFF, 16'h0001, s, c, rid, wt, lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL dir1_timeout"); end
    checks++; if ({c, rid, s} !== {1'b1, 1'b1, 16'h0000}) begin errors++;
      $display("FAIL dir1_result got c=%b id=%b sum=%h want c=1 id=1 sum=0000", c, rid, s); end
  endtask

  task automatic test_tie();
    logic [W-1:0] s; logic c, rid, to; int wt, lat;
    apply_reset();
    a1 = 16'h8000; b1 = 16'h8000; v1 = 1'b1;
    do_txn(1'b0, 16'h00FF, 16'h0001, s, c, rid, wt, lat, to);
    checks++; if ({to, wt} !== {1'b0, 32'd0}) begin errors++;
      $display("FAIL tie_first_grant got to=%b wait=%0d want immediate", to, wt); end
    checks++; if ({c, rid, s} !== {1'b0, 1'b0, 16'h0100}) begin errors++;
      $display("FAIL tie_first got c=%b id=%b sum=%h want c=0 id=0 sum=0100", c, rid, s); end
    do_txn(1'b1, 16'h8000, 16'h8000, s, c, rid, wt, lat, to);
    checks++; if ({to, c, rid, s} !== {1'b0, 1'b1, 1'b1, 16'h0000}) begin errors++;
      $display("FAIL tie_second got to=%b c=%b id=%b sum=%h want c=1 id=1 sum=0000", to, c, rid, s); end
  endtask

  task automatic test_back_to_back();
    logic [W:0] eq[$]; logic iq[$]; logic seq[4]; logic rr, g0, g1; logic [W:0] e; int got;
    seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    rr = 1'b1; got = 0;
    a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd(); v0 = 1'b1; v1 = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
      #1;
      checks++; if (busy === 1'b1 && (r0 | r1) !== 1'b0) begin errors++;
        $display("FAIL b2b_ready_busy got ready=%b%b while busy want 00", r0, r1); end
      if (res_valid === 1'b1 && eq.size() > 0) begin
        e = eq.pop_front();
        checks++; if ({res_id, res_carry, res_sum} !== {seq[got], e}) begin errors++;
          $display("FAIL b2b_result got id=%b c=%b sum=%h want id=%b c=%b sum=%h",
                   res_id, res_carry, res_sum, seq[got], e[W], e[W-1:0]); end
        got++;
      end
      g0 = r0; g1 = r1;
      if (g0 | g1) begin
        checks++; if (g1 !== !rr) begin errors++;
          $display("FAIL b2b_grant got id=%b want %b", g1, !rr); end
        eq.push_back(g1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0}));
        iq.push_back(g1);
        rr = g1;
      end
      @(posedge clk); #1;
      if (g0) begin a0 = rnd(); b0 = rnd(); end
      if (g1) begin a1 = rnd(); b1 = rnd(); end
    end
    checks++; if (got !== 4) begin errors++;
      $display("FAIL b2b_count got %0d results want 4", got); end
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s; logic c, rid, to; int wt, lat;
    do_txn(1'b1, 16'h1111, 16'h2222, s, c, rid, wt, lat, to);
    checks++; if ({to, s} !== {1'b0, 16'h3333}) begin errors++;
      $display("FAIL mid_pre got to=%b sum=%h want sum=3333", to, s); end
    a0 = 16'h0F0F; b0 = 16'h00F1; v0 = 1'b1;
    #1;
    checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL mid_grant got %b want 1", r0); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({res_valid, busy, res_id, res_carry, r0} !== 5'b0 || res_sum !== '0) begin errors++;
      $display("FAIL mid_reset got v=%b busy=%b id=%b c=%b rdy=%b sum=%h want all 0",
               res_valid, busy, res_id, res_carry, r0, res_sum); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_no_result got %b want 0", res_valid); end
    rst_n = 1'b1;
    do_txn(1'b0, 16'h0F0F, 16'h00F1, s, c, rid, wt, lat, to);
    checks++; if ({to, wt, lat} !== {1'b0, 32'd0, 32'(NIB + 1)}) begin errors++;
      $display("FAIL mid_retry_timing got to=%b wait=%0d lat=%0d want 0 0 %0d", to, wt, lat, NIB + 1); end
    checks++; if ({c, rid, s} !== {1'b0, 1'b0, 16'h1000}) begin errors++;
      $display("FAIL mid_retry got c=%b id=%b sum=%h want c=0 id=0 sum=1000", c, rid, s); end
  endtask

  // Timeline model: a grant opens a NIB+1 cycle busy window whose last cycle strobes the result.
  task automatic test_random();
    logic [W:0] eq[$]; logic iq[$]; logic rr, g0, g1, eid; logic [W:0] e; int cd;
    apply_reset();
    rr = 1'b1; cd = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      #1;
      g0 = (cd == 0) && v0 && (!v1 || rr);
      g1 = (cd == 0) && v1 && (!v0 || !rr);
      checks++; if ({r0, r1} !== {g0, g1}) begin errors++;
        $display("FAIL rnd_ready cyc %0d got %b%b want %b%b", cyc, r0, r1, g0, g1); end
      checks++; if (busy !== (cd != 0)) begin errors++;
        $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, cd != 0); end
      checks++; if (res_valid !== (cd == 1)) begin errors++;
        $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, res_valid, cd == 1); end
      if (cd == 1 && eq.size() > 0) begin
        e = eq.pop_front(); eid = iq.pop_front();
        checks++; if ({res_id, res_carry, res_sum} !== {eid, e}) begin errors++;
          $display("FAIL rnd_result cyc %0d got id=%b c=%b sum=%h want id=%b c=%b sum=%h",
                   cyc, res_id, res_carry, res_sum, eid, e[W], e[W-1:0]); end
      end
      if (g0 | g1) begin
        eq.push_back(g1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0}));
        iq.push_back(g1);
        rr = g1; cd = NIB + 1;
      end else if (cd > 0) cd--;
      @(posedge clk); #1;
      if (g0) begin
        if ($urandom_range(0, 1) == 1) begin a0 = rnd(); b0 = rnd(); end else v0 = 1'b0;
      end else if (v0 && $urandom_range(0, 9) == 0) v0 = 1'b0;
      else if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1'b1; a0 = rnd(); b0 = rnd(); end
      if (g1) begin
        if ($urandom_range(0, 1) == 1) begin a1 = rnd(); b1 = rnd(); end else v1 = 1'b0;
      end else if (v1 && $urandom_range(0, 9) == 0) v1 = 1'b0;
      else if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1'b1; a1 = rnd(); b1 = rnd(); end
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_tie();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
